fc_mac_seq: RTL and testbench
=============================

FC_MAC_SEQ -- requirements
Module: fc_mac_seq

Interface
REQ-001 Parameters SHALL be:
- DATA_BITWIDTH, default 8, feature/weight/result width (signed).
- ACC_BITWIDTH, default 15, partial-sum width fed to MAC data_c (signed).
- OUT_BITWIDTH, default 16, MAC mout width (signed).
- VEC_LEN, default 64, elements per neuron.
- ADDR_BITWIDTH, default 6, buffer address width; 2^ADDR_BITWIDTH >= VEC_LEN.
- OUT_SHIFT, default 4, right shift applied before output clamp.
REQ-002 Ports SHALL be:
- clk  in  1  sole clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin one neuron computation.
- bias  in  ACC_BITWIDTH  signed bias, sampled with start.
- rd_en  out  1  feature/weight buffer read strobe.
- rd_addr  out  ADDR_BITWIDTH  shared feature/weight read address.
- feat_rd_data  in  DATA_BITWIDTH  feature, valid the cycle after rd_en.
- wgt_rd_data  in  DATA_BITWIDTH  weight, valid the cycle after rd_en.
- mac_en  out  1  one-cycle MAC issue strobe.
- mac_data_a / mac_data_b  out  DATA_BITWIDTH  feature / weight to MAC.
- mac_data_c  out  ACC_BITWIDTH  running partial sum to MAC.
- mac_done  in  1  MAC completion pulse.
- mac_mout  in  OUT_BITWIDTH  MAC result.
- busy  out  1  high from accepted start until result_valid.
- result  out  DATA_BITWIDTH  signed neuron output.
- result_valid  out  1  one-cycle pulse, result valid.

Function
REQ-003 FSM states SHALL be IDLE, FETCH, READ, ISSUE, WAIT_MAC, POST.
REQ-004 IDLE: start=1 SHALL latch bias into acc, clear idx, go to FETCH; start in any other state SHALL be ignored.
REQ-005 FETCH: rd_en=1 and rd_addr=idx for exactly one cycle; next state READ.
REQ-006 READ: feat_rd_data/wgt_rd_data SHALL be registered into operand registers; next state ISSUE.
REQ-007 ISSUE: mac_en=1 for exactly one cycle with mac_data_a/b = registered operands and mac_data_c = acc; operands SHALL be held stable until mac_done; next state WAIT_MAC.
REQ-008 WAIT_MAC: SHALL wait with no timeout on mac_done; on mac_done, acc SHALL load mac_mout saturated to signed ACC_BITWIDTH range [-16384, 16383].
REQ-009 After capture: if idx = VEC_LEN-1 go to POST, else idx+1 and go to FETCH.
REQ-010 POST: result = clamp(max(acc,0) >>> OUT_SHIFT, 0, 2^(DATA_BITWIDTH-1)-1); result_valid=1 for one cycle; next state IDLE.
REQ-011 result SHALL hold its value until the next POST.
REQ-012 busy SHALL be 1 in every state except IDLE.
REQ-013 mac_en SHALL never be 1 in two consecutive cycles, nor while waiting for mac_done.
REQ-014 mac_done arriving outside WAIT_MAC SHALL be ignored.
REQ-015 Latency with the team's 4-cycle MAC (done visible 4 cycles after the en cycle): 7 cycles per element; result_valid SHALL assert 7*VEC_LEN+2 cycles after the start edge.
REQ-016 start coincident with the result_valid cycle SHALL be ignored; start is accepted only from IDLE.

Reset
REQ-017 rst=1 SHALL immediately force the FSM to IDLE and drive busy, rd_en, mac_en, result_valid to 0, rd_addr, idx, acc, operands to 0, and result to 0.
REQ-018 rst mid-computation SHALL abandon the neuron with no result_valid; the integrator SHALL drive the MAC's active-low reset from the inverse of rst so both blocks reset together.

Verification
REQ-019 VEC_LEN=4, features 16, weights 2, bias 0 -> result=8 (acc 128), result_valid exactly 30 cycles after start.
REQ-020 VEC_LEN=4, features 16, weights -2, bias 0 -> acc -128, result=0.
REQ-021 VEC_LEN=4, features 127, weights 127, bias 0 -> acc saturates at 16383 from element 2 onward, result=127.
REQ-022 VEC_LEN=4, weights 0, bias 100 -> result=6; then bias -5 -> result=0.
REQ-023 Second start pulsed during busy -> ignored, exactly one result_valid, rd_addr sequence 0,1,2,3 only.
REQ-024 rst asserted during WAIT_MAC of element 2 -> all outputs 0 within the reset cycle, no result_valid; a fresh start then gives the correct result.

Source files
------------

// File: rtl/fc_mac_seq.sv
// Fully-connected neuron sequencer: walks VEC_LEN feature/weight pairs through an
// external multi-cycle MAC, then rescales and clamps the accumulated sum to DATA_BITWIDTH.
//
// state    | meaning
// IDLE     | waiting for start; bias is loaded into acc when it arrives
// FETCH    | read strobe for element idx
// READ     | buffer data registered into the operand registers
// ISSUE    | single-cycle MAC issue with the operands and the running sum
// WAIT_MAC | hold operands until mac_done, then capture the saturated result
// POST     | shift, clamp and publish the neuron output
module fc_mac_seq #(
  parameter int DATA_BITWIDTH = 8,
  parameter int ACC_BITWIDTH  = 15,
  parameter int OUT_BITWIDTH  = 16,
  parameter int VEC_LEN       = 64,
  parameter int ADDR_BITWIDTH = 6,
  parameter int OUT_SHIFT     = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic signed [ACC_BITWIDTH-1:0]  bias,
  output logic                            rd_en,
  output logic [ADDR_BITWIDTH-1:0]        rd_addr,
  input  logic signed [DATA_BITWIDTH-1:0] feat_rd_data,
  input  logic signed [DATA_BITWIDTH-1:0] wgt_rd_data,
  output logic                            mac_en,
  output logic signed [DATA_BITWIDTH-1:0] mac_data_a,
  output logic signed [DATA_BITWIDTH-1:0] mac_data_b,
  output logic signed [ACC_BITWIDTH-1:0]  mac_data_c,
  input  logic                            mac_done,
  input  logic signed [OUT_BITWIDTH-1:0]  mac_mout,
  output logic                            busy,
  output logic signed [DATA_BITWIDTH-1:0] result,
  output logic                            result_valid
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_FETCH    = 3'd1;
  localparam logic [2:0] S_READ     = 3'd2;
  localparam logic [2:0] S_ISSUE    = 3'd3;
  localparam logic [2:0] S_WAIT_MAC = 3'd4;
  localparam logic [2:0] S_POST     = 3'd5;

  localparam logic signed [OUT_BITWIDTH-1:0] SAT_HI =
    OUT_BITWIDTH'((1 <<< (ACC_BITWIDTH-1)) - 1);
  localparam logic signed [OUT_BITWIDTH-1:0] SAT_LO =
    OUT_BITWIDTH'(-(1 <<< (ACC_BITWIDTH-1)));
  localparam logic signed [ACC_BITWIDTH-1:0] RES_MAX =
    ACC_BITWIDTH'((1 <<< (DATA_BITWIDTH-1)) - 1);
  localparam logic [ADDR_BITWIDTH-1:0] LAST_IDX = ADDR_BITWIDTH'(VEC_LEN - 1);

  logic [2:0]                      state;
  logic [ADDR_BITWIDTH-1:0]        idx;
  logic signed [ACC_BITWIDTH-1:0]  acc;
  logic signed [DATA_BITWIDTH-1:0] op_a;
  logic signed [DATA_BITWIDTH-1:0] op_b;
  logic signed [ACC_BITWIDTH-1:0]  mout_sat;
  logic signed [ACC_BITWIDTH-1:0]  acc_shift;
  logic signed [DATA_BITWIDTH-1:0] res_next;

  assign busy       = (state != S_IDLE);
  assign rd_en      = (state == S_FETCH);
  assign rd_addr    = idx;
  assign mac_en     = (state == S_ISSUE);
  assign mac_data_a = op_a;
  assign mac_data_b = op_b;
  assign mac_data_c = acc;

  always_comb begin
    mout_sat = mac_mout[ACC_BITWIDTH-1:0];
    if (mac_mout > SAT_HI)
      mout_sat = SAT_HI[ACC_BITWIDTH-1:0];
    else if (mac_mout < SAT_LO)
      mout_sat = SAT_LO[ACC_BITWIDTH-1:0];
  end

  // Negative sums rectify to zero before the shift; positives clamp at the signed max.
  always_comb begin
    acc_shift = acc >>> OUT_SHIFT;
    res_next  = acc_shift[DATA_BITWIDTH-1:0];
    if (acc[ACC_BITWIDTH-1])
      res_next = '0;
    else if (acc_shift > RES_MAX)
      res_next = RES_MAX[DATA_BITWIDTH-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      idx          <= '0;
      acc          <= '0;
      op_a         <= '0;
      op_b         <= '0;
      result       <= '0;
      result_valid <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          // result_valid is still high in the first IDLE cycle; a start there is dropped.
          if (start && !result_valid) begin
            acc   <= bias;
            idx   <= '0;
            state <= S_FETCH;
          end
        end
        S_FETCH: state <= S_READ;
        S_READ: begin
          op_a  <= feat_rd_data;
          op_b  <= wgt_rd_data;
          state <= S_ISSUE;
        end
        S_ISSUE: state <= S_WAIT_MAC;
        S_WAIT_MAC: begin
          if (mac_done) begin
            acc <= mout_sat;
            if (idx == LAST_IDX) begin
              state <= S_POST;
            end else begin
              idx   <= idx + 1'b1;
              state <= S_FETCH;
            end
          end
        end
        S_POST: begin
          result       <= res_next;
          result_valid <= 1'b1;
          state        <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fc_mac_seq.sv
// Bench for fc_mac_seq: 4-cycle MAC and sync buffer models, an arithmetic neuron model,
// a per-cycle output checker and directed neuron vectors.
module tb_fc_mac_seq;
  localparam int D  = 8;
  localparam int A  = 15;
  localparam int O  = 16;
  localparam int N  = 4;
  localparam int AW = 2;
  localparam int SH = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic                start;
  logic signed [A-1:0] bias;
  logic                rd_en;
  logic [AW-1:0]       rd_addr;
  logic signed [D-1:0] feat_rd_data = '0;
  logic signed [D-1:0] wgt_rd_data = '0;
  logic                mac_en;
  logic signed [D-1:0] mac_data_a;
  logic signed [D-1:0] mac_data_b;
  logic signed [A-1:0] mac_data_c;
  logic                mac_done;
  logic signed [O-1:0] mac_mout;
  logic                busy;
  logic signed [D-1:0] result;
  logic                result_valid;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fc_mac_seq #(.DATA_BITWIDTH(D), .ACC_BITWIDTH(A), .OUT_BITWIDTH(O), .VEC_LEN(N),
               .ADDR_BITWIDTH(AW), .OUT_SHIFT(SH)) dut (
    .clk(clk), .rst(rst), .start(start), .bias(bias),
    .rd_en(rd_en), .rd_addr(rd_addr), .feat_rd_data(feat_rd_data), .wgt_rd_data(wgt_rd_data),
    .mac_en(mac_en), .mac_data_a(mac_data_a), .mac_data_b(mac_data_b), .mac_data_c(mac_data_c),
    .mac_done(mac_done), .mac_mout(mac_mout), .busy(busy), .result(result),
    .result_valid(result_valid));

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Buffers: data appears the cycle after the read strobe
  logic signed [D-1:0] feat_mem [N];
  logic signed [D-1:0] wgt_mem  [N];
  always @(posedge clk) begin
    if (rd_en) begin
      feat_rd_data <= feat_mem[rd_addr];
      wgt_rd_data  <= wgt_mem[rd_addr];
    end
  end

  // MAC: done is high in the 4th cycle after the enable cycle, reset together with the DUT
  int                  mac_cnt;
  logic                mac_done_i;
  logic                stray_done;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mac_cnt    <= 0;
      mac_done_i <= 1'b0;
      mac_mout   <= '0;
    end else begin
      mac_done_i <= (mac_cnt == 1);
      if (mac_en) begin
        mac_cnt  <= 3;
        mac_mout <= O'(mac_data_a * mac_data_b + mac_data_c);
      end else if (mac_cnt > 0) begin
        mac_cnt <= mac_cnt - 1;
      end
    end
  end
  assign mac_done = mac_done_i | stray_done;

  // Neuron model: plain integer arithmetic over the whole vector
  int exp_c [N];
  int exp_acc;
  int exp_res;
  int gen = 0;

  task automatic load(input int f [N], input int w [N], input int b);
    int acc;
    acc = b;
    for (int i = 0; i < N; i++) begin
      feat_mem[i] = D'(f[i]);
      wgt_mem[i]  = D'(w[i]);
      exp_c[i]    = acc;
      acc = acc + f[i] * w[i];
      if (acc > 16383) acc = 16383;
      if (acc < -16384) acc = -16384;
    end
    exp_acc = acc;
    exp_res = (acc < 0) ? 0 : (acc >>> SH);
    if (exp_res > 127) exp_res = 127;
  endtask

  // Per-cycle checker
  int  done_cnt = 0;
  int  addr_next = 0;
  int  en_count = 0;
  int  rd_total = 0;
  int  rv_count = 0;
  bit  prev_en = 0;
  bit  outstanding = 0;
  logic signed [D-1:0] held_a, held_b;

  always @(negedge clk) begin
    if (rst) begin
      addr_next   = 0;
      en_count    = 0;
      prev_en     = 0;
      outstanding = 0;
      done_cnt    = gen;
    end else begin
      if (rd_en) begin
        chk("rd_addr", int'(rd_addr), addr_next);
        addr_next++;
        rd_total++;
      end
      if (mac_en) begin
        chk("mac_en_back_to_back", int'(prev_en), 0);
        chk("mac_en_while_waiting", int'(outstanding), 0);
        if (en_count < N) begin
          chk("mac_data_a", int'(mac_data_a), int'(feat_mem[en_count]));
          chk("mac_data_b", int'(mac_data_b), int'(wgt_mem[en_count]));
          chk("mac_data_c", int'(mac_data_c), exp_c[en_count]);
        end
        held_a      = mac_data_a;
        held_b      = mac_data_b;
        outstanding = 1;
        en_count++;
      end else if (outstanding) begin
        chk("operand_a_held", int'(mac_data_a), int'(held_a));
        chk("operand_b_held", int'(mac_data_b), int'(held_b));
        if (mac_done) outstanding = 0;
      end
      if (result_valid) begin
        rv_count++;
        chk("result_valid_expected", int'(gen != done_cnt), 1);
        chk("result_model", int'(result), exp_res);
        chk("mac_issues_per_neuron", en_count, N);
        done_cnt  = gen;
        addr_next = 0;
        en_count  = 0;
      end
      prev_en = mac_en;
    end
  end

  task automatic pulse_start(input int b);
    @(posedge clk); #1;
    start = 1'b1;
    bias  = A'(b);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_neuron(input int b, input int exp_lit, input bit dup);
    int cyc;
    int rv0;
    int rd0;
    bit got;
    rv0 = rv_count;
    rd0 = rd_total;
    gen++;
    pulse_start(b);
    chk("busy_after_start", int'(busy), 1);
    cyc = 1;
    got = 0;
    while (cyc < 80 && !got) begin
      @(posedge clk); #1;
      cyc++;
      start = (dup && cyc == 10);
      if (result_valid) got = 1;
    end
    chk("latency", cyc, 7 * N + 2);
    chk("result_literal", int'(result), exp_lit);
    if (dup) begin
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("start_in_valid_cycle_ignored", int'(busy), 0);
    end
    repeat (3) @(posedge clk);
    #1;
    chk("result_hold", int'(result), exp_lit);
    chk("busy_idle", int'(busy), 0);
    chk("valid_pulses", rv_count - rv0, 1);
    chk("reads_per_neuron", rd_total - rd0, N);
  endtask

  initial begin
    int cyc;
    int rv0;
    rst = 1'b1; start = 1'b0; bias = '0; stray_done = 1'b0;
    for (int i = 0; i < N; i++) begin feat_mem[i] = '0; wgt_mem[i] = '0; end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_rd_en", int'(rd_en), 0);
    chk("rst_mac_en", int'(mac_en), 0);
    chk("rst_valid", int'(result_valid), 0);
    chk("rst_result", int'(result), 0);
    chk("rst_rd_addr", int'(rd_addr), 0);
    chk("rst_data_c", int'(mac_data_c), 0);
    @(negedge clk);
    rst = 1'b0;

    load('{16, 16, 16, 16}, '{2, 2, 2, 2}, 0);
    chk("model_acc_pos", exp_acc, 128);
    chk("model_res_pos", exp_res, 8);
    run_neuron(0, 8, 0);

    load('{16, 16, 16, 16}, '{-2, -2, -2, -2}, 0);
    chk("model_acc_neg", exp_acc, -128);
    run_neuron(0, 0, 0);

    load('{127, 127, 127, 127}, '{127, 127, 127, 127}, 0);
    chk("model_sat_c2", exp_c[2], 16383);
    run_neuron(0, 127, 0);

    load('{50, -7, 99, 3}, '{0, 0, 0, 0}, 100);
    chk("model_bias_only", exp_res, 6);
    run_neuron(100, 6, 0);
    load('{50, -7, 99, 3}, '{0, 0, 0, 0}, -5);
    run_neuron(-5, 0, 0);

    // acc: 20 -> 17 -> 27 -> 48 -> 44, result 2; with duplicate starts
    load('{1, 2, 3, 4}, '{-3, 5, 7, -1}, 20);
    chk("model_mixed", exp_acc, 44);
    run_neuron(20, 2, 1);

    // Stray mac_done while idle
    rv0 = rv_count;
    @(posedge clk); #1;
    stray_done = 1'b1;
    @(posedge clk); #1;
    stray_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("stray_done_busy", int'(busy), 0);
    chk("stray_done_valid", rv_count - rv0, 0);
    chk("stray_done_result", int'(result), 2);

    // Reset during WAIT_MAC of element 2
    load('{16, 16, 16, 16}, '{2, 2, 2, 2}, 0);
    gen++;
    rv0 = rv_count;
    pulse_start(0);
    cyc = 0;
    while (cyc < 40 && !(rd_en && rd_addr == 2'd2)) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("reached_fetch_2", int'(cyc < 40), 1);
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_rd_en", int'(rd_en), 0);
    chk("midrst_mac_en", int'(mac_en), 0);
    chk("midrst_valid", int'(result_valid), 0);
    chk("midrst_rd_addr", int'(rd_addr), 0);
    chk("midrst_data_a", int'(mac_data_a), 0);
    chk("midrst_data_c", int'(mac_data_c), 0);
    chk("midrst_result", int'(result), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    chk("midrst_no_valid", rv_count - rv0, 0);
    run_neuron(0, 8, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
